// File: rtl/memory_bank_router_if.sv
// Bus bundle for memory_bank_router: input stream, RAM write port, bank-done report and release/busy masks.
// slave = router side, master = source/reader side.
interface memory_bank_router_if #(
  parameter int MEM_NUM          = 6,
  parameter int OUTPUT_MEM_DEPTH = 6,
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = $clog2(OUTPUT_MEM_DEPTH),
  parameter int LEN_WIDTH        = $clog2(OUTPUT_MEM_DEPTH + 1),
  parameter int IDX_WIDTH        = $clog2(MEM_NUM)
);
  logic                  data_iv;
  logic                  data_ir;
  logic [DATA_WIDTH-1:0] data_id;
  logic                  data_ilast;
  logic [MEM_NUM-1:0]    mem_ov;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] mem_od;
  logic                  bank_done_ov;
  logic [IDX_WIDTH-1:0]  bank_done_idx;
  logic [LEN_WIDTH-1:0]  bank_done_len;
  logic [MEM_NUM-1:0]    bank_release_i;
  logic [MEM_NUM-1:0]    bank_busy_o;

  modport slave (
    input  data_iv, data_id, data_ilast, bank_release_i,
    output data_ir, mem_ov, addr_o, mem_od,
           bank_done_ov, bank_done_idx, bank_done_len, bank_busy_o
  );

  modport master (
    output data_iv, data_id, data_ilast, bank_release_i,
    input  data_ir, mem_ov, addr_o, mem_od,
           bank_done_ov, bank_done_idx, bank_done_len, bank_busy_o
  );
endinterface

// File: rtl/memory_bank_router.sv
// Round-robin frame router into MEM_NUM RAM banks with per-bank occupancy and backpressure.
// Optional MEM_ROUTER_STATS_EN adds saturating frame and stall counters.
module memory_bank_router #(
  parameter int MEM_NUM          = 6,
  parameter int OUTPUT_MEM_DEPTH = 6,
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = $clog2(OUTPUT_MEM_DEPTH),
  parameter int LEN_WIDTH        = $clog2(OUTPUT_MEM_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_bank_router_if.slave   bus
`ifdef MEM_ROUTER_STATS_EN
  ,
  output logic [15:0]           frame_cnt_o,
  output logic [15:0]           stall_cnt_o
`endif
);

  localparam int IDX_WIDTH = $clog2(MEM_NUM);

  typedef enum logic {FILL, WAIT} state_t;

  state_t                state, state_next;
  logic [IDX_WIDTH-1:0]  cur_bank, cur_bank_next;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_next;
  logic [MEM_NUM-1:0]    busy, busy_next, close_set;
  logic                  accept, close;

  logic [MEM_NUM-1:0]    mem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  done_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [LEN_WIDTH-1:0]  len_q;

  // A frame closes on last or when the bank fills; release and close of one cycle both apply.
  always_comb begin
    accept        = bus.data_iv && (state == FILL);
    close         = accept && (bus.data_ilast || (wr_ptr == ADDR_WIDTH'(OUTPUT_MEM_DEPTH - 1)));
    close_set     = close ? (MEM_NUM'(1) << cur_bank) : '0;
    busy_next     = (busy & ~bus.bank_release_i) | close_set;
    cur_bank_next = cur_bank;
    wr_ptr_next   = wr_ptr;
    if (close) begin
      wr_ptr_next   = '0;
      cur_bank_next = (cur_bank == IDX_WIDTH'(MEM_NUM - 1)) ? '0 : cur_bank + 1'b1;
    end else if (accept) begin
      wr_ptr_next = wr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (close) state_next = busy_next[cur_bank_next] ? WAIT : FILL;
      WAIT:    if (!busy_next[cur_bank]) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      cur_bank <= '0;
      wr_ptr   <= '0;
      busy     <= '0;
      mem_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      len_q    <= '0;
    end else begin
      state    <= state_next;
      cur_bank <= cur_bank_next;
      wr_ptr   <= wr_ptr_next;
      busy     <= busy_next;
      mem_q    <= accept ? (MEM_NUM'(1) << cur_bank) : '0;
      if (accept) begin
        addr_q <= wr_ptr;
        data_q <= bus.data_id;
      end
      done_q <= close;
      if (close) begin
        idx_q <= cur_bank;
        len_q <= LEN_WIDTH'(wr_ptr) + LEN_WIDTH'(1);
      end
    end
  end

  assign bus.data_ir       = (state == FILL);
  assign bus.mem_ov        = mem_q;
  assign bus.addr_o        = addr_q;
  assign bus.mem_od        = data_q;
  assign bus.bank_done_ov  = done_q;
  assign bus.bank_done_idx = idx_q;
  assign bus.bank_done_len = len_q;
  assign bus.bank_busy_o   = busy;

`ifdef MEM_ROUTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (done_q && (frame_cnt_o != 16'hFFFF)) frame_cnt_o <= frame_cnt_o + 16'd1;
      if (bus.data_iv && (state != FILL) && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
